// File: rtl/apb_master.sv
// APB requester: takes single commands on a valid/ready port, runs them through
// IDLE -> SETUP -> ACCESS and returns a buffered response, with a PREADY timeout.
module apb_master #(
  parameter int AWIDTH  = 4,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_count;
  logic       accept;
  logic       rsp_done;
  logic       timed_out;

  assign accept    = cmd_valid && cmd_ready;
  assign rsp_done  = rsp_valid && rsp_ready;
  assign timed_out = !PREADY && (wait_count == 8'(TIMEOUT - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (PREADY || timed_out) state_next = RESP;
      RESP:    if (rsp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and bus strobes are registered from the next state so they come
  // out glitch-free and stay low for the whole reset, rising one cycle after it.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cmd_ready   <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_count  <= '0;
    end else begin
      cmd_ready <= (state_next == IDLE);
      PSEL      <= (state_next == SETUP) || (state_next == ACCESS);
      PENABLE   <= (state_next == ACCESS);
      rsp_valid <= (state_next == RESP);

      if (accept) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
      end

      if (state == ACCESS && state_next == ACCESS) wait_count <= wait_count + 8'd1;
      else                                         wait_count <= '0;

      // PREADY on the final counted edge still completes normally.
      if (state == ACCESS && PREADY) begin
        rsp_rdata   <= PWRITE ? '0 : PRDATA;
        rsp_err     <= PSLVERR;
        rsp_timeout <= 1'b0;
      end else if (state == ACCESS && timed_out) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
